fb_access_arbiter: RTL
======================

Name: fb_access_arbiter

Overview:
- Shares the single framebuffer random-access port (sel/wr/mask/address/data/ack) between NUM_REQ requesters, for example CPU, rasterizer and blitter.
- Arbitration is round-robin. One transaction is outstanding at a time.
- Sits in the clk_pix domain between the requesters and the framebuffer access port.
- Each requester keeps the same sel/ack protocol it would use talking to the framebuffer directly.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 24, address width.
- DATA_W, 16, data width.
- TIMEOUT_CYCLES, 1023, ISSUE-state watchdog limit; used only with FB_ARB_TIMEOUT_EN.

Ports:
- clk_pix  in  1  clock; all logic on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_sel_i  in  NUM_REQ  per-requester request; held until its ack.
- req_wr_i  in  NUM_REQ  1 = write, 0 = read.
- req_mask_i  in  4*NUM_REQ  byte/lane mask; requester r at [4r+3:4r].
- req_address_i  in  ADDR_W*NUM_REQ  packed addresses.
- req_data_in_i  in  DATA_W*NUM_REQ  packed write data.
- req_ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err_o  out  NUM_REQ  one-cycle timeout pulse, coincident with ack.
- req_data_out_o  out  DATA_W  read data; valid only while a req_ack_o bit is high.
- grant_o  out  $clog2(NUM_REQ) (min 1)  index of current/last granted requester.
- busy_o  out  1  high when state != IDLE.
- fb_sel_o  out  1  to framebuffer sel_i.
- fb_wr_o  out  1  to framebuffer wr_i.
- fb_mask_o  out  4  to framebuffer mask_i.
- fb_address_o  out  ADDR_W  to framebuffer address_i.
- fb_data_o  out  DATA_W  to framebuffer data_in_i.
- fb_ack_i  in  1  from framebuffer ack_o.
- fb_data_i  in  DATA_W  from framebuffer data_out_o.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; all outputs 0, including req_ack_o, req_err_o, req_data_out_o, fb_* and busy_o. grant_o = NUM_REQ-1 (last-grant pointer), so requester 0 wins first.
- FSM has four states: IDLE, ISSUE, DONE, RELEASE.
- IDLE:
  - If any req_sel_i bit is high, pick the first set bit searching from (grant+1) mod NUM_REQ upward with wrap.
  - Register grant_o and the winner's wr/mask/address/data into fb_*.
  - Set fb_sel_o = 1 and go to ISSUE.
  - The fb_* command fields stay stable until the next grant.
- ISSUE:
  - Hold fb_sel_o = 1.
  - On fb_ack_i = 1: capture fb_data_i into req_data_out_o, set req_ack_o[grant] = 1, set fb_sel_o = 0, go to DONE.
  - Requester inputs are ignored in this state; changes to req_sel_i do not affect the outstanding transaction.
- DONE (exactly one cycle):
  - req_ack_o[grant] is high in this cycle only.
  - The requester must drop req_sel_i in the cycle after it sees ack.
  - Go to RELEASE.
- RELEASE:
  - req_ack_o = 0, req_data_out_o = 0.
  - Stay until fb_ack_i = 0, then go to IDLE. This tolerates a level-held ack from the framebuffer.
- Latency: req_sel_i seen high at IDLE edge t gives fb_sel_o high from t+1. An fb_ack_i seen at edge k gives req_ack_o high at k+1. Minimum request-to-ack is 3 cycles. Back-to-back grants are separated by at least 2 idle cycles on fb_sel_o.
- Fairness: with all requesters asserted continuously, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- A single requester re-asserting immediately after its ack is granted again; no starvation penalty applies.
- A requester that drops req_sel_i before it is granted is simply skipped; no transaction is issued for it.
- Reset mid-transaction: fb_sel_o drops the cycle after reset_i is sampled. No ack is issued and the transaction is abandoned; the framebuffer is reset by the same reset_i.
- Read vs write: req_data_out_o is updated for both. Write acks return whatever fb_data_i holds; requesters ignore it.

Optional Feature:
- Macro: FB_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs while in ISSUE, cleared on entry.
  - When it reaches TIMEOUT_CYCLES without fb_ack_i, go to DONE with req_ack_o[grant] = 1, req_err_o[grant] = 1, req_data_out_o = 0 and fb_sel_o = 0.
  - RELEASE then waits for fb_ack_i = 0 as normal.
- When undefined:
  - No counter is built; ISSUE waits indefinitely.
  - req_err_o is tied to 0.

Test Plan:
- Single write: requester 0 writes 0xBEEF at address 0x000000, mask 0xF; framebuffer model acks after 10 cycles. Expect fb_sel_o high for exactly the ISSUE duration, fb_address_o = 0, fb_data_o = 0xBEEF, fb_wr_o = 1, and a one-cycle req_ack_o = 01 one cycle after fb_ack_i.
- Read-back: requester 1 reads address 0x000000 with the model returning 0xBEEF. Expect req_ack_o = 10 and req_data_out_o = 0xBEEF in the same cycle; req_data_out_o = 0 the following cycle.
- Contention: NUM_REQ = 3, all three assert sel at the same cycle and each re-asserts right after its ack. Expect grant order 0,1,2,0,1,2 over 6 transactions, and never two fb_sel_o transactions overlapping.
- Level-held ack: the model keeps fb_ack_i high for 5 cycles after sel drops. Expect the arbiter to stay in RELEASE (busy_o = 1), with no new fb_sel_o until fb_ack_i = 0 and no duplicate req_ack_o.
- Reset mid-ISSUE: assert reset_i for 1 cycle while fb_sel_o = 1. Expect fb_sel_o = 0, req_ack_o = 0 and grant_o = NUM_REQ-1 on the next cycle, and requester 0 winning first afterwards.
- Timeout (FB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): the model never acks. Expect req_ack_o and req_err_o for the granted requester 17 cycles after ISSUE entry, with req_data_out_o = 0. Without the macro, expect no ack after 1000 cycles and req_err_o = 0 throughout.

Source files
------------

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: round-robin share of one framebuffer access port among NUM_REQ requesters.
// Optional ISSUE watchdog enabled by defining FB_ARB_TIMEOUT_EN.
`default_nettype none

module fb_access_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                       clk_pix,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_sel_i,
  input  logic [NUM_REQ-1:0]         req_wr_i,
  input  logic [4*NUM_REQ-1:0]       req_mask_i,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_address_i,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data_in_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic [NUM_REQ-1:0]         req_err_o,
  output logic [DATA_W-1:0]          req_data_out_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_o,
  output logic                       busy_o,
  output logic                       fb_sel_o,
  output logic                       fb_wr_o,
  output logic [3:0]                 fb_mask_o,
  output logic [ADDR_W-1:0]          fb_address_o,
  output logic [DATA_W-1:0]          fb_data_o,
  input  logic                       fb_ack_i,
  input  logic [DATA_W-1:0]          fb_data_i
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       grant_nxt;
  logic                sel_nxt, wr_nxt;
  logic [3:0]          mask_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
  logic [NUM_REQ-1:0]  ack_nxt;
  logic                found;
  logic [GW-1:0]       win;
  int                  idx;

`ifdef FB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  err_nxt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign req_err_o      = '0;
`endif

  assign busy_o = (state != IDLE);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_o;
    sel_nxt   = fb_sel_o;
    wr_nxt    = fb_wr_o;
    mask_nxt  = fb_mask_o;
    addr_nxt  = fb_address_o;
    wdata_nxt = fb_data_o;
    rdata_nxt = '0;
    ack_nxt   = '0;
    found     = 1'b0;
    win       = grant_o;
    idx       = 0;
`ifdef FB_ARB_TIMEOUT_EN
    cnt_nxt   = cnt;
    err_nxt   = '0;
`endif

    // Search starts just after the last grant so every requester gets a turn.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(grant_o) + i) % NUM_REQ;
      if (!found && req_sel_i[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = win;
          sel_nxt   = 1'b1;
          wr_nxt    = req_wr_i[win];
          mask_nxt  = req_mask_i[4*int'(win) +: 4];
          addr_nxt  = req_address_i[ADDR_W*int'(win) +: ADDR_W];
          wdata_nxt = req_data_in_i[DATA_W*int'(win) +: DATA_W];
          state_nxt = ISSUE;
`ifdef FB_ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      ISSUE: begin
        if (fb_ack_i) begin
          rdata_nxt         = fb_data_i;
          ack_nxt[grant_o]  = 1'b1;
          sel_nxt           = 1'b0;
          state_nxt         = DONE;
        end
`ifdef FB_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES)) begin
          ack_nxt[grant_o]  = 1'b1;
          err_nxt[grant_o]  = 1'b1;
          sel_nxt           = 1'b0;
          state_nxt         = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      DONE: state_nxt = RELEASE;
      // A framebuffer may hold ack as a level; wait for it to fall first.
      RELEASE: if (!fb_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (reset_i) begin
      state          <= IDLE;
      grant_o        <= GW'(NUM_REQ - 1);
      fb_sel_o       <= 1'b0;
      fb_wr_o        <= 1'b0;
      fb_mask_o      <= '0;
      fb_address_o   <= '0;
      fb_data_o      <= '0;
      req_ack_o      <= '0;
      req_data_out_o <= '0;
`ifdef FB_ARB_TIMEOUT_EN
      cnt            <= '0;
      req_err_o      <= '0;
`endif
    end else begin
      state          <= state_nxt;
      grant_o        <= grant_nxt;
      fb_sel_o       <= sel_nxt;
      fb_wr_o        <= wr_nxt;
      fb_mask_o      <= mask_nxt;
      fb_address_o   <= addr_nxt;
      fb_data_o      <= wdata_nxt;
      req_ack_o      <= ack_nxt;
      req_data_out_o <= rdata_nxt;
`ifdef FB_ARB_TIMEOUT_EN
      cnt            <= cnt_nxt;
      req_err_o      <= err_nxt;
`endif
    end
  end

endmodule

`default_nettype wire
